serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Serial-to-parallel front stage that sits directly upstream of the byte queue in TOP.
- Captures one bit from data_in on each write_in strobe; after DATA_WIDTH bits it presents the assembled word to the queue through a valid/ack handshake.
- status_out tells the external sender when bits may be sent. write_in pulses are slow (many clock_1MHz cycles long), so strobes are edge-detected.

Parameters:
- DATA_WIDTH, 8, number of bits per assembled word (legal range 2..16).
- LSB_FIRST, 1, 1 = first received bit lands in data_out[0]; 0 = first received bit lands in data_out[DATA_WIDTH-1].

Ports:
- clock_1MHz  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
- data_in  input  1  serial data bit, sampled on a detected write_in rising edge.
- write_in  input  1  bit strobe, level signal of arbitrary length (≥1 cycle).
- status_out  output  1  1 = ready to accept serial bits (COLLECT state).
- data_out  output  DATA_WIDTH  assembled word; stable while data_valid_out=1.
- data_valid_out  output  1  word available to the downstream queue.
- data_ack_in  input  1  downstream queue consumed the word (sampled at a clock edge).
- bit_count_out  output  $clog2(DATA_WIDTH+1)  number of bits captured in the current word.
- overrun_out  output  1  one-cycle pulse when a write_in edge arrives outside COLLECT.

Behaviour:
- Reset (rst=0): state=INIT, shift register=0, bit count=0, status_out=0, data_valid_out=0, data_out=0, overrun_out=0. The write_in history register is forced to 1, so a write_in held high across reset release is not treated as an edge.
- States: INIT -> COLLECT -> HOLD -> COLLECT.
- INIT: lasts exactly one clock after rst rises, then goes to COLLECT. status_out rises at that edge, giving the sender a clean posedge.
- Edge detect: write_q <= write_in every cycle; strobe = write_in & ~write_q. One strobe per write_in pulse regardless of pulse length.
- COLLECT, on strobe:
  - data_in is captured at that same edge.
  - LSB_FIRST=1: shift right with the new bit entering at MSB, so after DATA_WIDTH bits the first bit is at bit 0.
  - LSB_FIRST=0: shift left with the new bit entering at LSB.
  - bit_count increments.
- On the strobe that captures bit DATA_WIDTH (same edge):
  - the full word is loaded into data_out;
  - data_valid_out <= 1, status_out <= 0, bit_count <= 0;
  - state -> HOLD.
  - Latency: data_valid_out is high in the cycle after the last bit's strobe edge.
- HOLD:
  - data_out and data_valid_out are held until data_ack_in=1 at a clock edge.
  - At that edge: data_valid_out <= 0, status_out <= 1, state -> COLLECT.
  - data_ack_in while data_valid_out=0 is ignored.
- Strobe in INIT or HOLD: the bit is discarded, overrun_out pulses high for exactly one cycle, and the shift register and count are unchanged.
- Strobe and data_ack_in on the same edge in HOLD: the ack is honoured, the bit is discarded and flagged as overrun. Bits are never captured in HOLD.
- data_out is not cleared on ack; it retains the last word until the next word completes.
- Reset mid-word or mid-HOLD: the partial word and any pending word are lost; the block restarts through INIT.
- bit_count_out is 0..DATA_WIDTH-1 in COLLECT and 0 in INIT and HOLD.

Test Plan:
- Reset behaviour: rst=0 for 2.5 us with write_in=1 throughout, then release. Required: all outputs 0 during reset; status_out rises 1 cycle after release; no bit captured and no overrun pulse.
- Basic word: send 8'b10101010 LSB-first (bits 0,1,0,1,0,1,0,1), each write_in pulse 10 us high / 10 us low, ack held 0. Required: data_valid_out=1 with data_out=8'hAA one cycle after the 8th strobe; status_out=0; bit_count_out steps 1..7 then 0.
- Handshake: in HOLD, pulse data_ack_in for 1 cycle. Required: data_valid_out falls and status_out rises on that edge. A second word 8'h3C then appears correctly on data_out.
- Long pulses: write_in held high for 25 cycles per bit. Required: exactly one capture per pulse, and a word of 8'hFF yields exactly 8 counts.
- Overrun: 3 write_in pulses during HOLD. Required: 3 single-cycle overrun_out pulses; data_out is unchanged at 8'hAA.
- Reset mid-word: 4 bits sent, then rst=0 for 1 cycle. Required: bit_count_out=0, status_out=0 then 1, and the next 8 bits 8'h55 assemble correctly. Repeat the basic-word test with LSB_FIRST=0: bits 1,0,1,0,1,0,1,0 yield 8'hAA.

Source files
------------

// File: rtl/serial_deserializer_if.sv
// serial_deserializer_if
//   Parallel word handshake between the serial deserializer and the byte
//   queue that consumes its words.
//   data_out       : assembled word, stable while data_valid_out is high
//   data_valid_out : a word is waiting for the queue
//   data_ack_in    : queue has taken the word (sampled on a clock edge)
//   master modport : the deserializer side (drives data/valid)
//   slave modport  : the queue side (drives ack)
interface serial_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid_out;
  logic                  data_ack_in;

  modport master (
    output data_out,
    output data_valid_out,
    input  data_ack_in
  );

  modport slave (
    input  data_out,
    input  data_valid_out,
    output data_ack_in
  );
endinterface

// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Serial-to-parallel front stage for the byte queue. One bit of data_in is
//   captured per rising edge of the (slow) write_in strobe; after DATA_WIDTH
//   bits the word is offered to the queue over a valid/ack handshake.
//   clock_1MHz    : system clock, rising edge active
//   rst           : asynchronous active-low reset
//   data_in       : serial data bit, sampled on a detected write_in edge
//   write_in      : bit strobe, level of arbitrary length
//   status_out    : 1 while bits may be sent (COLLECT state)
//   bit_count_out : bits captured so far in the current word
//   overrun_out   : one-cycle pulse for a strobe seen outside COLLECT
//   bus           : word handshake (data_out, data_valid_out, data_ack_in)
module serial_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1,
  localparam int CW        = $clog2(DATA_WIDTH + 1)
) (
  input  logic                        clock_1MHz,
  input  logic                        rst,
  input  logic                        data_in,
  input  logic                        write_in,
  output logic                        status_out,
  output logic [CW-1:0]               bit_count_out,
  output logic                        overrun_out,
  serial_deserializer_if.master       bus
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic [CW-1:0]         count_q,   count_d;
  logic                  valid_q,   valid_d;
  logic                  status_q,  status_d;
  logic                  overrun_q, overrun_d;
  logic                  write_q;

  logic                  strobe;
  logic [DATA_WIDTH-1:0] shift_next;

  // One strobe per write_in pulse, no matter how long the pulse is held.
  assign strobe = write_in & ~write_q;

  // Shift direction decides where the first received bit ends up: shifting
  // right with the new bit at the MSB leaves the first bit at bit 0.
  always_comb begin
    shift_next = '0;
    if (LSB_FIRST) begin
      shift_next = {data_in, shift_q[DATA_WIDTH-1:1]};
    end else begin
      shift_next = {shift_q[DATA_WIDTH-2:0], data_in};
    end
  end

  // Next-state and output logic. Strobes outside COLLECT are dropped and
  // flagged; an ack in HOLD wins even if a strobe lands on the same edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    count_d   = count_q;
    valid_d   = valid_q;
    status_d  = status_q;
    overrun_d = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        state_d  = ST_COLLECT;
        status_d = 1'b1;
        if (strobe) begin
          overrun_d = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (strobe) begin
          if (count_q == CW'(DATA_WIDTH - 1)) begin
            data_d   = shift_next;
            shift_d  = '0;
            count_d  = '0;
            valid_d  = 1'b1;
            status_d = 1'b0;
            state_d  = ST_HOLD;
          end else begin
            shift_d = shift_next;
            count_d = count_q + CW'(1);
          end
        end
      end

      ST_HOLD: begin
        if (bus.data_ack_in) begin
          valid_d  = 1'b0;
          status_d = 1'b1;
          state_d  = ST_COLLECT;
        end
        if (strobe) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d  = ST_INIT;
        status_d = 1'b0;
        valid_d  = 1'b0;
        count_d  = '0;
      end
    endcase
  end

  // State registers. The write_in history resets to 1 so a strobe held high
  // across reset release is not mistaken for a new edge.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      shift_q   <= '0;
      data_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      status_q  <= 1'b0;
      overrun_q <= 1'b0;
      write_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      status_q  <= status_d;
      overrun_q <= overrun_d;
      write_q   <= write_in;
    end
  end

  assign status_out         = status_q;
  assign bit_count_out      = count_q;
  assign overrun_out        = overrun_q;
  assign bus.data_out       = data_q;
  assign bus.data_valid_out = valid_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer
//   Directed bench for serial_deserializer. Two instances share clock and
//   reset: dut_a is LSB-first, dut_b is MSB-first. Expected words are
//   hand-computed constants.
`timescale 1ns/1ps
module tb_serial_deserializer;

  logic       clock_1MHz;
  logic       rst;
  logic [1:0] data_in;
  logic [1:0] write_in;
  logic [1:0] ack;
  logic [1:0] status;
  logic [1:0] overrun;
  logic [3:0] bit_count [2];
  logic [7:0] dout      [2];
  logic [1:0] valid;

  int vector_count;
  int miscompare_count;
  int ov_cycles_a;
  int ov_base;

  serial_deserializer_if #(.DATA_WIDTH(8)) bus_a ();
  serial_deserializer_if #(.DATA_WIDTH(8)) bus_b ();

  assign bus_a.data_ack_in = ack[0];
  assign bus_b.data_ack_in = ack[1];
  assign dout[0]  = bus_a.data_out;
  assign dout[1]  = bus_b.data_out;
  assign valid[0] = bus_a.data_valid_out;
  assign valid[1] = bus_b.data_valid_out;

  serial_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
    .clock_1MHz    (clock_1MHz),
    .rst           (rst),
    .data_in       (data_in[0]),
    .write_in      (write_in[0]),
    .status_out    (status[0]),
    .bit_count_out (bit_count[0]),
    .overrun_out   (overrun[0]),
    .bus           (bus_a.master)
  );

  serial_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .clock_1MHz    (clock_1MHz),
    .rst           (rst),
    .data_in       (data_in[1]),
    .write_in      (write_in[1]),
    .status_out    (status[1]),
    .bit_count_out (bit_count[1]),
    .overrun_out   (overrun[1]),
    .bus           (bus_b.master)
  );

  // 1 MHz clock
  initial clock_1MHz = 1'b0;
  always #500 clock_1MHz = ~clock_1MHz;

  // Count cycles in which dut_a flags an overrun, sampled mid-cycle.
  always @(negedge clock_1MHz) begin
    if (overrun[0] === 1'b1) ov_cycles_a++;
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Send n_bits serial bits (seq[0] first) to the selected instance. Checks
  // the bit count right after each strobe edge and again at the end of the
  // high phase, and the completed word on the 8th bit.
  task automatic applyStimulus(input int sel, input logic [7:0] seq,
                               input logic [7:0] exp_word, input int n_bits,
                               input int high_cycles, input int low_cycles);
    logic [3:0] exp_count;
    for (int i = 0; i < n_bits; i++) begin
      data_in[sel]  = seq[i];
      write_in[sel] = 1'b1;
      @(negedge clock_1MHz);
      exp_count = (i == 7) ? 4'd0 : 4'(i + 1);
      checkOutput("bit_count", 16'(bit_count[sel]), 16'(exp_count));
      if (i == 7) begin
        checkOutput("valid_after_word", 16'(valid[sel]), 16'd1);
        checkOutput("data_after_word", 16'(dout[sel]), 16'(exp_word));
        checkOutput("status_in_hold", 16'(status[sel]), 16'd0);
      end
      repeat (high_cycles - 1) @(negedge clock_1MHz);
      checkOutput("count_end_of_pulse", 16'(bit_count[sel]), 16'(exp_count));
      write_in[sel] = 1'b0;
      repeat (low_cycles) @(negedge clock_1MHz);
    end
  endtask

  task automatic ackWord(input int sel);
    ack[sel] = 1'b1;
    @(negedge clock_1MHz);
    ack[sel] = 1'b0;
    checkOutput("valid_after_ack", 16'(valid[sel]), 16'd0);
    checkOutput("status_after_ack", 16'(status[sel]), 16'd1);
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    ov_cycles_a      = 0;
    data_in  = 2'b00;
    write_in = 2'b01;
    ack      = 2'b00;
    rst      = 1'b1;
    #10 rst  = 1'b0;

    // Reset with write_in held high on dut_a
    #2500;
    @(negedge clock_1MHz);
    checkOutput("rst_status", 16'(status[0]), 16'd0);
    checkOutput("rst_valid", 16'(valid[0]), 16'd0);
    checkOutput("rst_data", 16'(dout[0]), 16'h00);
    checkOutput("rst_count", 16'(bit_count[0]), 16'd0);
    checkOutput("rst_overrun", 16'(overrun[0]), 16'd0);
    rst = 1'b1;
    #1;
    checkOutput("status_at_release", 16'(status[0]), 16'd0);
    @(negedge clock_1MHz);
    checkOutput("status_one_after_release", 16'(status[0]), 16'd1);
    repeat (4) @(negedge clock_1MHz);
    checkOutput("no_capture_held_write", 16'(bit_count[0]), 16'd0);
    write_in[0] = 1'b0;
    repeat (3) @(negedge clock_1MHz);
    checkOutput("no_overrun_after_reset", 16'(ov_cycles_a), 16'd0);

    // Basic word, LSB-first, 10 us pulses
    applyStimulus(0, 8'hAA, 8'hAA, 8, 10, 10);
    checkOutput("valid_held", 16'(valid[0]), 16'd1);
    checkOutput("data_held", 16'(dout[0]), 16'hAA);

    // Three strobes while a word is pending
    ov_base = ov_cycles_a;
    for (int p = 0; p < 3; p++) begin
      data_in[0]  = 1'b1;
      write_in[0] = 1'b1;
      repeat (3) @(negedge clock_1MHz);
      write_in[0] = 1'b0;
      repeat (3) @(negedge clock_1MHz);
    end
    checkOutput("overrun_cycles", 16'(ov_cycles_a - ov_base), 16'd3);
    checkOutput("data_after_overrun", 16'(dout[0]), 16'hAA);
    checkOutput("count_after_overrun", 16'(bit_count[0]), 16'd0);

    // Handshake, then ack while nothing is pending is ignored
    ackWord(0);
    checkOutput("data_kept_after_ack", 16'(dout[0]), 16'hAA);
    ack[0] = 1'b1;
    @(negedge clock_1MHz);
    ack[0] = 1'b0;
    checkOutput("stray_ack_valid", 16'(valid[0]), 16'd0);
    checkOutput("stray_ack_status", 16'(status[0]), 16'd1);

    // Second word, then ack and strobe on the same edge
    applyStimulus(0, 8'h3C, 8'h3C, 8, 10, 10);
    ov_base     = ov_cycles_a;
    data_in[0]  = 1'b1;
    write_in[0] = 1'b1;
    ack[0]      = 1'b1;
    @(negedge clock_1MHz);
    ack[0] = 1'b0;
    checkOutput("ack_strobe_valid", 16'(valid[0]), 16'd0);
    checkOutput("ack_strobe_status", 16'(status[0]), 16'd1);
    checkOutput("ack_strobe_count", 16'(bit_count[0]), 16'd0);
    checkOutput("ack_strobe_overrun", 16'(overrun[0]), 16'd1);
    repeat (3) @(negedge clock_1MHz);
    write_in[0] = 1'b0;
    repeat (3) @(negedge clock_1MHz);
    checkOutput("ack_strobe_ov_cycles", 16'(ov_cycles_a - ov_base), 16'd1);
    checkOutput("ack_strobe_no_capture", 16'(bit_count[0]), 16'd0);
    checkOutput("ack_strobe_data", 16'(dout[0]), 16'h3C);

    // Long pulses: 25 cycles high per bit
    applyStimulus(0, 8'hFF, 8'hFF, 8, 25, 5);
    ackWord(0);

    // Reset in the middle of a word
    applyStimulus(0, 8'h0F, 8'h00, 4, 3, 3);
    rst = 1'b0;
    #1;
    checkOutput("midword_rst_count", 16'(bit_count[0]), 16'd0);
    checkOutput("midword_rst_status", 16'(status[0]), 16'd0);
    @(negedge clock_1MHz);
    rst = 1'b1;
    #1;
    checkOutput("midword_release_status", 16'(status[0]), 16'd0);
    @(negedge clock_1MHz);
    checkOutput("midword_status_back", 16'(status[0]), 16'd1);
    applyStimulus(0, 8'h55, 8'h55, 8, 4, 4);
    ackWord(0);

    // MSB-first instance: bits 1,0,1,0,1,0,1,0 assemble to AA
    applyStimulus(1, 8'h55, 8'hAA, 8, 10, 10);
    ackWord(1);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
